// File: rtl/ifr_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package ifr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MEM_WAIT,
        RESP,
        DRAIN,
        PF_WAIT
    } ifr_state_e;

    localparam logic [31:0] SPARC_NOP = 32'h0100_0000;

endpackage

// File: rtl/ifr_timeout_ctr.sv
// Wait-cycle counter: clear/enable, saturating, terminal flag at TIMEOUT-1.
module ifr_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    assign terminal = (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: one outstanding PC request against a variable-latency memory.
// Defining IFR_PREFETCH_EN adds a one-entry next-line prefetch buffer.
module imem_fetch_responder
    import ifr_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_pc,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic              rsp_err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
);
    ifr_state_e        state, state_nxt;
    logic              drain_after, drain_after_nxt;
    logic [31:0]       rsp_instr_nxt;
    logic              rsp_err_nxt;
    logic              rd_issue;
    logic [ADDR_W-1:0] rd_addr;
    logic              ctr_clear, ctr_enable, ctr_terminal;
    logic [ADDR_W-1:0] req_word;

    function automatic logic pc_ok(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc[31:ADDR_W+2] == '0);
    endfunction

    assign req_word  = req_pc[ADDR_W+1:2];
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

`ifdef IFR_PREFETCH_EN
    logic              pf_valid;
    logic [ADDR_W-1:0] pf_addr;
    logic [31:0]       pf_data;
    logic [ADDR_W-1:0] pc_word;
    logic              pf_load;
    logic              pf_hit;

    assign pf_hit = pf_valid && (req_word == pf_addr);
`endif

    ifr_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (ctr_clear),
        .enable   (ctr_enable),
        .terminal (ctr_terminal)
    );

    always_comb begin
        state_nxt       = state;
        drain_after_nxt = drain_after;
        rsp_instr_nxt   = rsp_instr;
        rsp_err_nxt     = rsp_err;
        rd_issue        = 1'b0;
        rd_addr         = mem_addr;
        ctr_clear       = 1'b0;
        ctr_enable      = 1'b0;
`ifdef IFR_PREFETCH_EN
        pf_load         = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    drain_after_nxt = 1'b0;
                    if (!pc_ok(req_pc)) begin
                        state_nxt     = RESP;
                        rsp_instr_nxt = SPARC_NOP;
                        rsp_err_nxt   = 1'b1;
                    end
`ifdef IFR_PREFETCH_EN
                    else if (pf_hit) begin
                        state_nxt     = RESP;
                        rsp_instr_nxt = pf_data;
                        rsp_err_nxt   = 1'b0;
                    end
`endif
                    else begin
                        state_nxt = MEM_WAIT;
                        rd_issue  = 1'b1;
                        rd_addr   = req_word;
                        ctr_clear = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                ctr_enable = 1'b1;
                if (flush) begin
                    // A read completing in the flush cycle leaves nothing to drain.
                    state_nxt = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    state_nxt     = RESP;
                    rsp_instr_nxt = mem_rdata;
                    rsp_err_nxt   = 1'b0;
                end else if (ctr_terminal) begin
                    state_nxt       = RESP;
                    rsp_instr_nxt   = SPARC_NOP;
                    rsp_err_nxt     = 1'b1;
                    drain_after_nxt = 1'b1;
                end
            end
            RESP: begin
                if (flush || rsp_ready) begin
                    if (drain_after) begin
                        state_nxt = DRAIN;
                    end
`ifdef IFR_PREFETCH_EN
                    else if (!flush && !rsp_err && (pc_word != '1)) begin
                        state_nxt = PF_WAIT;
                        rd_issue  = 1'b1;
                        rd_addr   = pc_word + 1'b1;
                        ctr_clear = 1'b1;
                    end
`endif
                    else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
`ifdef IFR_PREFETCH_EN
            PF_WAIT: begin
                ctr_enable = 1'b1;
                if (flush) begin
                    state_nxt = mem_rvalid ? IDLE : DRAIN;
                end else if (mem_rvalid) begin
                    state_nxt = IDLE;
                    pf_load   = 1'b1;
                end else if (ctr_terminal) begin
                    state_nxt = DRAIN;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            drain_after <= 1'b0;
            rsp_instr   <= '0;
            rsp_err     <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
        end else begin
            state       <= state_nxt;
            drain_after <= drain_after_nxt;
            rsp_instr   <= rsp_instr_nxt;
            rsp_err     <= rsp_err_nxt;
            mem_rd_en   <= rd_issue;
            mem_addr    <= rd_addr;
        end
    end

`ifdef IFR_PREFETCH_EN
    // Buffer is consumed by a hit and invalidated by any other request or any flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_valid <= 1'b0;
            pf_addr  <= '0;
            pf_data  <= '0;
            pc_word  <= '0;
        end else begin
            if (pf_load) begin
                pf_valid <= 1'b1;
                pf_data  <= mem_rdata;
            end else if (flush || (state == IDLE && req_valid)) begin
                pf_valid <= 1'b0;
            end
            if (state == RESP && rd_issue) begin
                pf_addr <= rd_addr;
            end
            if (state == IDLE && req_valid && !flush) begin
                pc_word <= req_word;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: random and directed fetches against a queue-based model.
module tb_imem_fetch_responder;
    localparam int          ADDR_W  = 10;
    localparam int          TIMEOUT = 64;
    localparam logic [31:0] NOP     = 32'h0100_0000;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_pc;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_instr;
    logic              rsp_err;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    int                lat_cfg = 2;
    int                rd_count = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    bit                hold_low = 1'b0;
    logic [31:0]       mem_arr [1024];
    exp_t              sb [$];

    imem_fetch_responder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .flush      (flush),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_instr  (rsp_instr),
        .rsp_err    (rsp_err),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what the fetch stage must see for a request and the memory latency L,
    // where L counts edges from acceptance to the edge that samples mem_rvalid.
    function automatic void model(input logic [31:0] pc, input int lat, output exp_t e,
                                  output int edge_n, output int reads);
        if (pc[1:0] != 2'b00 || pc >= (32'd1 << (ADDR_W + 2))) begin
            e.instr = NOP; e.err = 1'b1; edge_n = 1; reads = 0;
        end else begin
            reads = 1;
            if (lat <= TIMEOUT) begin
                e.instr = mem_arr[pc / 4]; e.err = 1'b0; edge_n = lat + 1;
            end else begin
                e.instr = NOP; e.err = 1'b1; edge_n = TIMEOUT + 1;
            end
        end
    endfunction

    // Backing memory: answers each strobe once, lat_cfg edges after acceptance.
    initial begin
        int          pending;
        logic [ADDR_W-1:0] paddr;
        pending = 0; paddr = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending = 0;
            end else if (mem_rd_en) begin
                rd_count++;
                last_addr = mem_addr;
                paddr     = mem_addr;
                pending   = lat_cfg - 1;
            end
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (pending > 0 && !reset) begin
                pending--;
                if (pending == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_arr[paddr];
                end
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: every presented response must match the queue head until it is taken or flushed.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_rsp: got instr %0h err %0b, expected no response", rsp_instr, rsp_err);
            end else begin
                check("rsp_instr", rsp_instr, sb[0].instr);
                check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
                if (rsp_ready || flush) void'(sb.pop_front());
            end
        end
    end

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!req_ready && n < budget) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_wait: req_ready %0b after %0d cycles, expected 1", req_ready, budget);
        end
    endtask

    task automatic issue(input logic [31:0] pc, input int lat, output int t_acc);
        wait_ready(300);
        lat_cfg = lat; req_pc = pc; req_valid = 1'b1;
        @(posedge clk); #1;
        t_acc = cyc;
        req_valid = 1'b0; req_pc = $urandom;
    endtask

    task automatic run_txn(input logic [31:0] pc, input int lat, input int hold);
        exp_t e; int edge_n, reads, t0, rd0, n;
        model(pc, lat, e, edge_n, reads);
        if (hold > 0) hold_low = 1'b1;
        rd0 = rd_count;
        sb.push_back(e);
        issue(pc, lat, t0);
        n = 0;
        while (!rsp_valid && n < 300) begin @(posedge clk); #1; n++; end
        check("rsp_latency", 32'(cyc - t0 + 1), 32'(edge_n));
        for (int k = 0; k < hold; k++) begin
            check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            @(posedge clk); #1;
        end
        hold_low = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
        check("rsp_consumed", 32'(sb.size()), 32'd0);
        sb.delete();
        check("rd_pulses", 32'(rd_count - rd0), 32'(reads));
        if (reads == 1) check("mem_addr", 32'(last_addr), pc >> 2);
        if (reads == 1 && lat > TIMEOUT) begin
            check("drain_ready_low", 32'(req_ready), 32'd0);
            n = 0;
            while (!req_ready && n < 300) begin @(posedge clk); #1; n++; end
            check("drain_release_edge", 32'(cyc - t0), 32'(lat));
        end
    endtask

    task automatic run_flush_wait(input logic [31:0] pc, input int lat, input int d);
        int t0, rd0, n;
        rd0 = rd_count;
        issue(pc, lat, t0);
        repeat (d - 1) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready_low", 32'(req_ready), 32'd0);
        n = 0;
        while (!req_ready && n < 300) begin @(posedge clk); #1; n++; end
        check("flush_release_edge", 32'(cyc - t0), 32'(lat));
        check("flush_rd_pulses", 32'(rd_count - rd0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc;
        int          lat, kind, t0, rd0, n;
        exp_t        e;
        int          edge_n, reads;

        reset = 1'b1; req_valid = 1'b0; req_pc = '0; flush = 1'b0;
        foreach (mem_arr[i]) mem_arr[i] = $urandom;
        mem_arr[4] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_rsp_instr", rsp_instr, 32'd0);
        check("reset_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_txn(32'h0000_0010, 3, 0);
        run_txn(32'h0000_0012, 2, 0);
        run_txn(32'h0000_1000, 2, 0);
        run_txn(32'h0000_0020, TIMEOUT, 0);
        run_txn(32'h0000_0024, 100, 0);
        run_flush_wait(32'h0000_0030, 4, 2);
        run_txn(32'h0000_0044, 3, 5);

        // Flush while a response waits for rsp_ready: it must vanish.
        hold_low = 1'b1;
        model(32'h0000_0050, 2, e, edge_n, reads);
        sb.push_back(e);
        issue(32'h0000_0050, 2, t0);
        n = 0;
        while (!rsp_valid && n < 300) begin @(posedge clk); #1; n++; end
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("resp_flush_valid", 32'(rsp_valid), 32'd0);
        check("resp_flush_ready", 32'(req_ready), 32'd1);
        check("resp_flush_dropped", 32'(sb.size()), 32'd0);
        sb.delete();
        hold_low = 1'b0;

        // A request coinciding with flush in IDLE is not accepted.
        rd0 = rd_count;
        req_valid = 1'b1; req_pc = 32'h0000_0060; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("idle_flush_ready", 32'(req_ready), 32'd1);
        check("idle_flush_rd_en", 32'(mem_rd_en), 32'd0);
        check("idle_flush_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("idle_flush_reads", 32'(rd_count - rd0), 32'd0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            lat  = $urandom_range(2, 8);
            if (kind == 0) begin
                pc = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
                run_txn(pc, lat, 0);
            end else if (kind == 1) begin
                pc = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
                run_txn(pc, lat, 0);
            end else if (kind == 2) begin
                pc  = 32'($urandom_range(0, 1023)) << 2;
                lat = $urandom_range(3, 8);
                run_flush_wait(pc, lat, $urandom_range(1, lat - 1));
            end else begin
                pc = 32'($urandom_range(0, 1023)) << 2;
                run_txn(pc, lat, 0);
            end
        end

        // Asynchronous reset in the middle of a memory wait.
        issue(32'h0000_0040, 40, t0);
        repeat (5) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        check("midreset_req_ready", 32'(req_ready), 32'd1);
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_rsp_instr", rsp_instr, 32'd0);
        check("midreset_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_txn(32'h0000_0010, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
